// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1
//   Two-requester, one-responder arbiter for the core memory bus. Port 0 is
//   typically instruction fetch, port 1 the load/store unit. Requests are
//   arbitrated onto a single downstream request channel. In-order responses
//   are routed back to their issuer through a small routing FIFO of port ids.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mK_valid_i/ready_o     port K request handshake (K = 0, 1)
//   mK_addr_i/wdata_i      port K address / write data
//   mK_wmask_i             port K byte mask (all zero = read)
//   mK_rdata_o/rvalid_o    port K response (data broadcast, valid routed)
//   s_valid_o/ready_i      downstream request handshake
//   s_addr_o/wdata_o       downstream address / write data
//   s_wmask_o              downstream byte mask
//   s_rdata_i/rvalid_i     downstream response (one per accepted request)
//
// Configuration
//   BUS_ARB_FIXED_PRIO_EN  when defined, port 0 always wins contention and the
//                          round-robin priority pointer is removed.
module bus_arbiter_2to1 #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   m0_valid_i,
  output logic                   m0_ready_o,
  input  logic [AddrWidth-1:0]   m0_addr_i,
  input  logic [DataWidth-1:0]   m0_wdata_i,
  input  logic [DataWidth/8-1:0] m0_wmask_i,
  output logic [DataWidth-1:0]   m0_rdata_o,
  output logic                   m0_rvalid_o,
  input  logic                   m1_valid_i,
  output logic                   m1_ready_o,
  input  logic [AddrWidth-1:0]   m1_addr_i,
  input  logic [DataWidth-1:0]   m1_wdata_i,
  input  logic [DataWidth/8-1:0] m1_wmask_i,
  output logic [DataWidth-1:0]   m1_rdata_o,
  output logic                   m1_rvalid_o,
  output logic                   s_valid_o,
  input  logic                   s_ready_i,
  output logic [AddrWidth-1:0]   s_addr_o,
  output logic [DataWidth-1:0]   s_wdata_o,
  output logic [DataWidth/8-1:0] s_wmask_o,
  input  logic [DataWidth-1:0]   s_rdata_i,
  input  logic                   s_rvalid_i
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = MaxOutstanding + 1;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e               state_q, state_d;
  logic                      lock_port_q, lock_port_d;
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]           wptr_q, wptr_d;
  logic [PtrW-1:0]           rptr_q, rptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

`ifndef BUS_ARB_FIXED_PRIO_EN
  logic                      prio_q, prio_d;
`endif

  logic gnt;
  logic gnt_valid;
  logic s_valid;
  logic hs;
  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic head;

  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rptr_q];

  // Grant selection: frozen while locked, otherwise single requester wins and
  // contention is resolved by the priority scheme.
  always_comb begin
    gnt = 1'b0;
    if (state_q == ST_LOCKED) begin
      gnt = lock_port_q;
    end else if (m0_valid_i && m1_valid_i) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      gnt = 1'b0;
`else
      gnt = prio_q;
`endif
    end else if (m1_valid_i) begin
      gnt = 1'b1;
    end
  end

  assign gnt_valid = gnt ? m1_valid_i : m0_valid_i;
  // rst_ni gates the request so outputs drop immediately on an async reset,
  // independent of whatever the requesters are still driving.
  assign s_valid   = rst_ni && gnt_valid && !fifo_full;
  assign hs        = s_valid && s_ready_i;
  assign push      = hs;
  assign pop       = s_rvalid_i && !fifo_empty;

  assign s_valid_o  = s_valid;
  assign s_addr_o   = gnt ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o  = gnt ? m1_wdata_i : m0_wdata_i;
  assign s_wmask_o  = gnt ? m1_wmask_i : m0_wmask_i;
  assign m0_ready_o = hs && !gnt;
  assign m1_ready_o = hs && gnt;

  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign m0_rvalid_o = pop && !head;
  assign m1_rvalid_o = pop && head;

  // Lock state machine and routing FIFO next-state.
  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    fifo_d      = fifo_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_FREE: begin
        if (s_valid && !s_ready_i) begin
          state_d     = ST_LOCKED;
          lock_port_d = gnt;
        end
      end
      ST_LOCKED: begin
        if (hs) begin
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase

    if (push) begin
      fifo_d[wptr_q] = gnt;
      wptr_d         = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifndef BUS_ARB_FIXED_PRIO_EN
  assign prio_d = hs ? ~gnt : prio_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_FREE;
      lock_port_q <= 1'b0;
      fifo_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a downstream protocol error.
  rvalid_when_empty_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(s_rvalid_i && fifo_empty)
  );
`endif

endmodule

// File: doc/bus_arbiter_2to1.md
Name: bus_arbiter_2to1

Overview:
- Two-requester, one-responder arbiter on the core memory bus.
- Typical use: instruction fetch (port 0) and load/store unit (port 1) share one memory responder.
- Sits directly upstream of the responder side of the bus. It presents a requester-side bus downstream and two responder-side buses upstream.
- Tracks outstanding requests so each in-order response is routed back to the requester that issued it.

Parameters:
- AddrWidth, 64, request address width.
- DataWidth, 64, data width. Byte mask is DataWidth/8 bits.
- MaxOutstanding, 4, depth of the response-routing FIFO (accepted but not yet answered requests). Power of two, at least 2.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset: asynchronous assert, active-low.
- m0_valid_i  input  1  port 0 request valid.
- m0_ready_o  output  1  port 0 request accepted this cycle.
- m0_addr_i  input  AddrWidth  port 0 address.
- m0_wdata_i  input  DataWidth  port 0 write data.
- m0_wmask_i  input  DataWidth/8  port 0 byte mask; all zero means read.
- m0_rdata_o  output  DataWidth  port 0 response data.
- m0_rvalid_o  output  1  port 0 response valid.
- m1_*  same set and meanings as m0_*, for port 1.
- s_valid_o  output  1  downstream request valid.
- s_ready_i  input  1  downstream accepts request.
- s_addr_o  output  AddrWidth  downstream address.
- s_wdata_o  output  DataWidth  downstream write data.
- s_wmask_o  output  DataWidth/8  downstream byte mask.
- s_rdata_i  input  DataWidth  downstream response data.
- s_rvalid_i  input  1  downstream response valid.

Behaviour:
- Handshakes:
  - A request transfers on a cycle with valid && ready.
  - The downstream returns exactly one s_rvalid_i pulse per accepted request, reads and writes alike, in acceptance order.
  - Responses have no backpressure.
- Reset (rst_ni low):
  - s_valid_o=0, m0_ready_o=0, m1_ready_o=0, m0_rvalid_o=0, m1_rvalid_o=0.
  - FIFO emptied, lock cleared, priority pointer=0.
  - Reset mid-operation discards all outstanding entries; the downstream responder must be reset together with this block.
- Grant (combinational, when not locked):
  - Only one port valid: that port wins.
  - Both ports valid: the port equal to the priority pointer wins.
- Lock:
  - Set when s_valid_o=1 and s_ready_i=0.
  - While locked, the grant is frozen to the locked port, and s_valid_o/addr/wdata/wmask stay stable until the handshake.
  - Cleared on the downstream handshake.
  - A granted requester must hold valid until accepted.
- s_valid_o = granted valid && !fifo_full. s_valid_o never depends on s_ready_i.
- s_addr_o/s_wdata_o/s_wmask_o are muxed from the granted port. When s_valid_o=0 they are don't-care.
- mK_ready_o = s_ready_i && s_valid_o && grant==K. Zero latency, so at most one port is ready per cycle.
- Priority pointer: after a downstream handshake by port K, pointer <= ~K. Otherwise unchanged.
- Routing FIFO: 1-bit entries holding the port id.
  - Push the granted id on a downstream handshake.
  - Pop on s_rvalid_i.
  - Pointers are log2(MaxOutstanding) bits and wrap; an occupancy counter is MaxOutstanding+1 wide.
  - Full blocks a new request even if a pop occurs the same cycle.
  - Push and pop in the same cycle (not full): occupancy unchanged.
  - A response in the same cycle as a push belongs to the FIFO head, i.e. the older request.
- Responses (combinational):
  - mK_rvalid_o = s_rvalid_i && !fifo_empty && head==K.
  - s_rdata_i is broadcast to m0_rdata_o and m1_rdata_o.
  - s_rvalid_i while the FIFO is empty is a protocol error: dropped, both rvalids stay 0, and a simulation assertion fires.

Optional Feature:
- Macro BUS_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are valid; the priority pointer is removed. Lock behaviour is unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Single read: m0 valid, addr=0x1000, wmask=0, s_ready_i=1 -> s_addr_o=0x1000 and m0_ready_o=1 the same cycle. s_rvalid_i two cycles later with rdata=0xDEAD -> m0_rvalid_o=1, m1_rvalid_o=0.
- Contention round-robin: m0 and m1 both valid every cycle, s_ready_i=1 -> accepted order m0, m1, m0, m1. Responses 0xA, 0xB, 0xC, 0xD are routed to m0, m1, m0, m1 respectively.
- Lock: m1 alone valid, addr=0x20, s_ready_i=0 for 3 cycles, m0 asserts valid in cycle 2 -> s_addr_o stays 0x20 and grant stays on m1. When s_ready_i=1, m1 is accepted, then m0.
- Full: s_ready_i=1, no responses, m0 issues 5 requests -> 4 accepted and s_valid_o=0 on the 5th. One s_rvalid_i -> 5th still blocked that cycle, accepted the next.
- Simultaneous push/pop: FIFO holds [m1], m0 handshake and s_rvalid_i in the same cycle -> m1_rvalid_o=1, FIFO then holds [m0] with occupancy 1.
- Async reset with 3 outstanding: rst_ni low mid-cycle -> all outputs 0 immediately. After release, a new m0 request completes normally.
